// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two WIDTH-bit operands through a single 4-bit
// adder slice, one nibble per clock, LSB nibble first, with valid/ready
// handshakes on both sides.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input that turns the
// operation into op_a - op_b (B inverted, nibble-0 carry forced to 1).
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [WIDTH-1:0]  a_reg, b_reg;
   logic              carry_reg;
   logic [IDXW-1:0]   idx;
   logic [IDXW+1:0]   bit_lo;
   logic [3:0]        a_nib, b_nib;
   logic [4:0]        slice;
   logic              accept;
   logic              last_nib;
`ifdef SERIAL_ADD_SUB_EN
   logic              sub_reg;
`endif

   assign accept   = (state == IDLE) && in_valid;
   assign last_nib = (idx == IDX_LAST);
   assign bit_lo   = {idx, 2'b00};

   // The one shared 4-bit adder slice, fed by the nibble selected by idx.
   always_comb begin
      a_nib = a_reg[bit_lo +: 4];
      b_nib = b_reg[bit_lo +: 4];
`ifdef SERIAL_ADD_SUB_EN
      if (sub_reg) begin
         b_nib = ~b_nib;
      end
`endif
      slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the two state-decoded outputs.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal
      // unassigned, which would otherwise infer a latch.
      state_next = state;
      in_ready   = (state == IDLE);
      busy       = (state != IDLE);
      unique case (state)
         IDLE:    if (in_valid)  state_next = RUN;
         RUN:     if (last_nib)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on accept.
   always_ff @(posedge clk) begin
      // NOTE: operand registers carry no reset; they are always loaded on the
      // accept edge before any nibble reads them, so reset would only cost area.
      if (accept) begin
         a_reg <= op_a;
         b_reg <= op_b;
      end
   end

   // Nibble sequencing, carry chain and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx       <= '0;
         carry_reg <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_reg   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  idx       <= '0;
`ifdef SERIAL_ADD_SUB_EN
                  sub_reg   <= sub;
                  carry_reg <= sub ? 1'b1 : cin;
`else
                  carry_reg <= cin;
`endif
               end
            end
            RUN: begin
               result[bit_lo +: 4] <= slice[3:0];
               carry_reg           <= slice[4];
               if (last_nib) begin
                  idx       <= '0;
                  cout      <= slice[4];
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl: directed cases plus randomized adds,
// each compared against a whole-word arithmetic reference model.
// Build with SERIAL_ADD_SUB_EN defined to also exercise subtraction.
module tb_nibble_serial_add_ctrl;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a, op_b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             busy;

   int checks = 0;
   int errors = 0;

   nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: whole-word arithmetic, carry/no-borrow in bit WIDTH.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic c, input logic s);
      logic [WIDTH-1:0] nb;
      nb = ~b;
      if (s) return {1'b0, a} + {1'b0, nb} + (WIDTH+1)'(1);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
   endfunction

   // One complete transaction; junk=1 drives a second request and changes
   // the operand bus while the first one is running. Called at a negedge.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        input logic s, input int hold, input bit junk);
      logic [WIDTH:0] exp;
      int n;
      exp = model(a, b, c, s);
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op_a = a; op_b = b; cin = c; sub = s;
      @(posedge clk);
      @(negedge clk);
      in_valid = junk;
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin
         check("busy_run", {30'd0, busy, in_ready}, 32'd2);
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("latency", n, NIB);
      check("result", {16'd0, result}, {16'd0, exp[WIDTH-1:0]});
      check("cout", {31'd0, cout}, {31'd0, exp[WIDTH]});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_state", {29'd0, out_valid, busy, in_ready}, 32'd6);
         check("hold_result", {15'd0, cout, result}, {15'd0, exp[WIDTH], exp[WIDTH-1:0]});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("back_idle", {29'd0, out_valid, busy, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_ctl", {29'd0, out_valid, busy, in_ready}, 32'd1);
      check("reset_data", {15'd0, cout, result}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
      do_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 6, 1'b0);
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1, 1'b1);
      do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0, 1'b0);

      // Reset while idx == 2.
      in_valid = 1'b1; op_a = 16'h7777; op_b = 16'h8888; cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_rst_ctl", {29'd0, out_valid, busy, in_ready}, 32'd1);
      check("midrun_rst_data", {15'd0, cout, result}, 32'd0);
      do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
      do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
`endif

      // Randomized transactions with random backpressure.
      for (int i = 0; i < 30; i++) begin
`ifdef SERIAL_ADD_SUB_EN
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom));
`else
         do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0,
               int'($urandom_range(0, 3)), 1'($urandom));
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
